mult_datapath: RTL

- Shift-and-add multiplier datapath: accumulator/multiplier register, add/shift logic and bit counter.
- Sits directly downstream of the multiplier control FSM. Consumes its Load/Sh/Ad strobes each clock.
- Returns M (current multiplier LSB) and K (last-shift flag) that steer the FSM's transitions.
- Unsigned N-bit x N-bit -> 2N-bit product.

---
 rtl/mult_pkg.sv | 28 ++
 rtl/mult_bit_counter.sv | 46 ++++
 rtl/mult_datapath.sv | 102 ++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mult_pkg
//  Purpose  : Shared definitions for the shift-and-add multiplier slice:
//             default operand width, accumulator width helper and the
//             control-FSM state encodings shared with the control block.
//  Revision : 1.0 - initial release
// ============================================================================
package mult_pkg;

    // Default operand width in bits.
    localparam int MULT_N = 4;

    // Accumulator width: N+1 upper bits (sum with carry) plus N multiplier bits.
    function automatic int acc_width(input int n);
        return 2 * n + 1;
    endfunction

    // Control FSM state encodings, shared with the multiplier control block.
    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } mult_state_t;

endpackage : mult_pkg
`default_nettype wire

// File: rtl/mult_bit_counter.sv
`default_nettype none
// ============================================================================
//  Module   : mult_bit_counter
//  Purpose  : CW-bit wrap-around step counter. Counts 0..MAX_CNT and wraps
//             back to 0; tc is high while the count equals MAX_CNT.
//  Ports    : Clk    - clock, rising edge
//             rst    - asynchronous active-low reset (count -> 0)
//             i_clr  - synchronous clear (priority over i_inc)
//             i_inc  - advance the count by one, wrapping after MAX_CNT
//             o_tc   - terminal count flag (count == MAX_CNT)
//  Revision : 1.0 - initial release
// ============================================================================
module mult_bit_counter #(
    parameter int CW      = 2,
    parameter int MAX_CNT = 3
) (
    input  logic Clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_tc
);

    localparam logic [CW-1:0] c_MAX = CW'(MAX_CNT);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            // Explicit wrap so non-power-of-two terminal counts work too.
            if (r_cnt == c_MAX) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_tc = (r_cnt == c_MAX);

endmodule : mult_bit_counter
`default_nettype wire

// File: rtl/mult_datapath.sv
`default_nettype none
// ============================================================================
//  Module   : mult_datapath
//  Purpose  : Shift-and-add multiplier datapath (unsigned N x N -> 2N).
//             Accumulator/multiplier register, inline adder, step counter.
//             Driven each clock by the Load/Sh/Ad strobes of the control
//             FSM; returns M (multiplier LSB) and K (last-shift flag).
//  Option   : MULT_RESULT_REG_EN - when defined, a result register captures
//             the product on Done and drives Product; otherwise Done is
//             ignored and Product is the live accumulator.
//  Ports    : Clk     - clock, rising edge
//             rst     - asynchronous active-low reset
//             Load    - capture Mplier, clear counter (highest priority)
//             Sh      - logical right shift of ACC, count one step
//             Ad      - add Mcand into upper ACC
//             Done    - result capture strobe (optional feature only)
//             Mcand   - multiplicand, held stable for the whole product
//             Mplier  - multiplier
//             M       - ACC[0]
//             K       - high when counter == N-1
//             Product - 2N-bit result
//  Revision : 1.0 - initial release
// ============================================================================
module mult_datapath
    import mult_pkg::*;
#(
    parameter int N  = MULT_N,
    parameter int CW = $clog2(N)
) (
    input  logic           Clk,
    input  logic           rst,
    input  logic           Load,
    input  logic           Sh,
    input  logic           Ad,
    input  logic           Done,
    input  logic [N-1:0]   Mcand,
    input  logic [N-1:0]   Mplier,
    output logic           M,
    output logic           K,
    output logic [2*N-1:0] Product
);

    localparam int c_ACC_W = acc_width(N);

    logic [c_ACC_W-1:0] r_acc;
    logic [N:0]         w_sum;
    logic               w_cnt_inc;

    // Add uses ACC[2N-1:N] only; ACC[2N] is always 0 before an add in a
    // normal sequence, and the carry of the N+1-bit sum lands there.
    assign w_sum = {1'b0, r_acc[2*N-1:N]} + {1'b0, Mcand};

    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            r_acc <= '0;
        end else if (Load) begin
            r_acc <= {{(N+1){1'b0}}, Mplier};
        end else if (Ad) begin
            r_acc[2*N:N] <= w_sum;
        end else if (Sh) begin
            r_acc <= {1'b0, r_acc[c_ACC_W-1:1]};
        end
    end

    // Counter only advances when Sh actually wins the priority arbitration.
    assign w_cnt_inc = Sh & ~Ad & ~Load;

    mult_bit_counter #(
        .CW      (CW),
        .MAX_CNT (N - 1)
    ) u_bit_counter (
        .Clk   (Clk),
        .rst   (rst),
        .i_clr (Load),
        .i_inc (w_cnt_inc),
        .o_tc  (K)
    );

    assign M = r_acc[0];

`ifdef MULT_RESULT_REG_EN
    logic [2*N-1:0] r_preg;

    // Independent of the ACC priority chain: captures even alongside Load.
    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            r_preg <= '0;
        end else if (Done) begin
            r_preg <= r_acc[2*N-1:0];
        end
    end

    assign Product = r_preg;
`else
    logic w_unused_done;
    assign w_unused_done = Done;

    assign Product = r_acc[2*N-1:0];
`endif

endmodule : mult_datapath
`default_nettype wire
